// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the 6502 fetch sequencer.
package fetch_seq_pkg;

   localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;

   typedef enum logic [2:0] {
      VEC_LO,
      VEC_HI,
      FETCH_OP,
      DECODE,
      FETCH_OPND,
      ISSUE,
      EXEC
   } state_e;

   typedef enum logic [1:0] {
      OP_SEQ     = 2'd0,
      OP_JMP_ABS = 2'd1,
      OP_BRANCH  = 2'd2
   } op_kind_e;

   // Raw decoder code 3 behaves as a plain sequential instruction.
   function automatic op_kind_e decode_kind(input logic [1:0] raw);
      case (raw)
         2'd1:    return OP_JMP_ABS;
         2'd2:    return OP_BRANCH;
         default: return OP_SEQ;
      endcase
   endfunction

   // Operand bytes still to fetch after the opcode; a length of 0 counts as 1.
   function automatic logic [1:0] len_to_remaining(input logic [1:0] len);
      return (len == 2'd0) ? 2'd0 : len - 2'd1;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Byte-wide read bus between the fetch sequencer (master) and memory (slave).
interface fetch_sequencer_if;

   logic        bus_req;
   logic [15:0] bus_addr;
   logic        bus_ready;
   logic [7:0]  bus_rdata;

   modport master (
      output bus_req,
      output bus_addr,
      input  bus_ready,
      input  bus_rdata
   );

   modport slave (
      input  bus_req,
      input  bus_addr,
      output bus_ready,
      output bus_rdata
   );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: loads the reset vector, fetches opcode plus operand bytes,
// hands the instruction to execute and issues the resulting PC update.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.master bus,
   input  logic [15:0]       pc_addr,
   input  logic [1:0]        op_len,
   input  logic [1:0]        op_kind,
   input  logic              branch_taken,
   input  logic              exec_done,
   output logic              pc_inc,
   output logic              pc_load,
   output logic [15:0]       pc_load_addr,
   output logic [7:0]        opcode_q,
   output logic [15:0]       operand_q,
   output logic              instr_valid
);

   state_e      state_q;
   state_e      state_d;
   logic [7:0]  vec_lo_q;
   logic [1:0]  remaining_q;
   logic        opnd_idx_q;
   op_kind_e    kind_q;
   logic        req;
   logic [15:0] addr;

   logic signed [15:0] branch_off;
   logic        [15:0] branch_target;

   assign bus.bus_req  = req;
   assign bus.bus_addr = addr;

   // Relative branch target wraps modulo 2^16 through the 16-bit add.
   assign branch_off    = {{8{operand_q[7]}}, operand_q[7:0]};
   assign branch_target = pc_addr + $unsigned(branch_off);

   // Next-state, bus request and PC strobe decode; reset suppresses every strobe.
   always_comb begin
      state_d      = state_q;
      req          = 1'b0;
      addr         = pc_addr;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
      pc_load_addr = 16'h0000;
      case (state_q)
         VEC_LO: begin
            req  = 1'b1;
            addr = RESET_VECTOR;
            if (bus.bus_ready) state_d = VEC_HI;
         end
         VEC_HI: begin
            req  = 1'b1;
            addr = RESET_VECTOR + 16'd1;
            if (bus.bus_ready) begin
               pc_load      = 1'b1;
               pc_load_addr = {bus.bus_rdata, vec_lo_q};
               state_d      = FETCH_OP;
            end
         end
         FETCH_OP: begin
            req = 1'b1;
            if (bus.bus_ready) begin
               pc_inc  = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = (len_to_remaining(op_len) == 2'd0) ? ISSUE : FETCH_OPND;
         end
         FETCH_OPND: begin
            req = 1'b1;
            if (bus.bus_ready) begin
               pc_inc = 1'b1;
               if (remaining_q == 2'd1) state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = EXEC;
         end
         EXEC: begin
            if (exec_done) begin
               state_d = FETCH_OP;
               case (kind_q)
                  OP_JMP_ABS: begin
                     pc_load      = 1'b1;
                     pc_load_addr = operand_q;
                  end
                  OP_BRANCH: begin
                     if (branch_taken) begin
                        pc_load      = 1'b1;
                        pc_load_addr = branch_target;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = VEC_LO;
      endcase
      if (rst) begin
         state_d      = VEC_LO;
         req          = 1'b0;
         pc_inc       = 1'b0;
         pc_load      = 1'b0;
         pc_load_addr = 16'h0000;
      end
   end

   // State register plus latched vector, opcode, operands and decode results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= VEC_LO;
         vec_lo_q    <= 8'h00;
         opcode_q    <= 8'h00;
         operand_q   <= 16'h0000;
         remaining_q <= 2'd0;
         opnd_idx_q  <= 1'b0;
         kind_q      <= OP_SEQ;
         instr_valid <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_valid <= (state_d == ISSUE);
         case (state_q)
            VEC_LO: begin
               if (bus.bus_ready) vec_lo_q <= bus.bus_rdata;
            end
            FETCH_OP: begin
               if (bus.bus_ready) begin
                  opcode_q  <= bus.bus_rdata;
                  operand_q <= 16'h0000;
               end
            end
            DECODE: begin
               kind_q      <= decode_kind(op_kind);
               remaining_q <= len_to_remaining(op_len);
               opnd_idx_q  <= 1'b0;
            end
            FETCH_OPND: begin
               if (bus.bus_ready) begin
                  if (!opnd_idx_q) operand_q[7:0]  <= bus.bus_rdata;
                  else             operand_q[15:8] <= bus.bus_rdata;
                  opnd_idx_q  <= 1'b1;
                  remaining_q <= remaining_q - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: small memory, PC counter and decoder models.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic [15:0] pc = 16'h0000;
   logic [1:0]  op_len;
   logic [1:0]  op_kind;
   logic        branch_taken;
   logic        exec_done;
   logic        pc_inc;
   logic        pc_load;
   logic [15:0] pc_load_addr;
   logic [7:0]  opcode_q;
   logic [15:0] operand_q;
   logic        instr_valid;

   logic [7:0]  mem [0:65535];

   int n_chk  = 0;
   int n_pass = 0;
   int inc_cnt  = 0;
   int load_cnt = 0;
   int both_cnt = 0;

   fetch_sequencer_if bus ();

   assign bus.bus_ready = ready;
   assign bus.bus_rdata = mem[bus.bus_addr];

   fetch_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .pc_addr      (pc),
      .op_len       (op_len),
      .op_kind      (op_kind),
      .branch_taken (branch_taken),
      .exec_done    (exec_done),
      .pc_inc       (pc_inc),
      .pc_load      (pc_load),
      .pc_load_addr (pc_load_addr),
      .opcode_q     (opcode_q),
      .operand_q    (operand_q),
      .instr_valid  (instr_valid)
   );

   always #5 clk = ~clk;

   // Decoder stand-in: EA = 1-byte SEQ, 4C = 3-byte JMP abs, D0 = 2-byte branch.
   always_comb begin
      op_len  = 2'd1;
      op_kind = 2'd0;
      case (opcode_q)
         8'h4C: begin op_len = 2'd3; op_kind = 2'd1; end
         8'hD0: begin op_len = 2'd2; op_kind = 2'd2; end
         default: ;
      endcase
   end

   // Program counter model and strobe counters.
   always @(posedge clk) begin
      if (pc_load)      pc <= pc_load_addr;
      else if (pc_inc)  pc <= pc + 16'd1;
      if (pc_inc)            inc_cnt  <= inc_cnt + 1;
      if (pc_load)           load_cnt <= load_cnt + 1;
      if (pc_inc && pc_load) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic wait_instr(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (instr_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_instr_valid"}, 32'(seen), 32'd1);
   endtask

   task automatic do_exec(input logic taken, output logic got_load, output logic [15:0] got_addr);
      @(negedge clk);
      exec_done    = 1'b1;
      branch_taken = taken;
      #1;
      got_load = pc_load;
      got_addr = pc_load_addr;
      @(negedge clk);
      exec_done    = 1'b0;
      branch_taken = 1'b0;
      #1;
   endtask

   initial begin
      logic        ld;
      logic [15:0] la;
      logic        stable;
      logic        found;
      int          base;

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'hFFFC] = 8'h34;  mem[16'hFFFD] = 8'h12;
      mem[16'h1234] = 8'hEA;
      mem[16'h1235] = 8'h4C;  mem[16'h1236] = 8'h00;  mem[16'h1237] = 8'h80;
      mem[16'h8000] = 8'h4C;  mem[16'h8001] = 8'hEE;  mem[16'h8002] = 8'hFF;
      mem[16'hFFEE] = 8'hD0;  mem[16'hFFEF] = 8'h20;
      mem[16'h0010] = 8'hD0;  mem[16'h0011] = 8'hFE;
      mem[16'h0012] = 8'h4C;  mem[16'h0013] = 8'h34;  mem[16'h0014] = 8'h12;

      rst = 1'b1; ready = 1'b1; exec_done = 1'b0; branch_taken = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("rst_bus_req",     32'(bus.bus_req),  32'd0);
      chk("rst_bus_addr",    32'(bus.bus_addr), 32'hFFFC);
      chk("rst_instr_valid", 32'(instr_valid),  32'd0);
      chk("rst_opcode",      32'(opcode_q),     32'h00);
      chk("rst_operand",     32'(operand_q),    32'h0000);
      chk("rst_pc_load",     32'(pc_load),      32'd0);
      chk("rst_pc_inc",      32'(pc_inc),       32'd0);

      // Reset vector fetch
      base = load_cnt;
      @(negedge clk); rst = 1'b0; #1;
      chk("vec_lo_req",  32'(bus.bus_req),  32'd1);
      chk("vec_lo_addr", 32'(bus.bus_addr), 32'hFFFC);
      @(negedge clk); #1;
      chk("vec_hi_addr",  32'(bus.bus_addr),  32'hFFFD);
      chk("vec_pc_load",  32'(pc_load),       32'd1);
      chk("vec_load_adr", 32'(pc_load_addr),  32'h1234);
      @(negedge clk); #1;
      chk("vec_load_once", 32'(load_cnt - base), 32'd1);
      chk("fetch_addr",    32'(bus.bus_addr),    32'h1234);

      // 1-byte SEQ
      base = inc_cnt;
      wait_instr("seq");
      chk("seq_opcode",  32'(opcode_q),         32'hEA);
      chk("seq_operand", 32'(operand_q),        32'h0000);
      chk("seq_incs",    32'(inc_cnt - base),   32'd1);
      do_exec(1'b0, ld, la);
      chk("seq_no_load", 32'(ld),               32'd0);
      chk("seq_next",    32'(bus.bus_addr),     32'h1235);
      chk("seq_iv_drop", 32'(instr_valid),      32'd0);

      // JMP absolute to 8000
      base = inc_cnt;
      wait_instr("jmp");
      chk("jmp_opcode",  32'(opcode_q),       32'h4C);
      chk("jmp_operand", 32'(operand_q),      32'h8000);
      chk("jmp_incs",    32'(inc_cnt - base), 32'd3);
      do_exec(1'b0, ld, la);
      chk("jmp_load",    32'(ld),             32'd1);
      chk("jmp_addr",    32'(la),             32'h8000);
      chk("jmp_next",    32'(bus.bus_addr),   32'h8000);

      // JMP to FFEE, then wrapping branch FFF0 + 0x20
      wait_instr("jmp2");
      do_exec(1'b0, ld, la);
      chk("jmp2_addr", 32'(la), 32'hFFEE);
      wait_instr("brw");
      chk("brw_pc", 32'(pc), 32'hFFF0);
      do_exec(1'b1, ld, la);
      chk("brw_load", 32'(ld), 32'd1);
      chk("brw_addr", 32'(la), 32'h0010);

      // Taken backward branch at 0012 with offset FE
      wait_instr("brb");
      chk("brb_pc", 32'(pc), 32'h0012);
      do_exec(1'b1, ld, la);
      chk("brb_load", 32'(ld), 32'd1);
      chk("brb_addr", 32'(la), 32'h0010);

      // Same branch not taken
      wait_instr("brn");
      do_exec(1'b0, ld, la);
      chk("brn_no_load", 32'(ld),           32'd0);
      chk("brn_next",    32'(bus.bus_addr), 32'h0012);

      // Operand stall on the first operand byte of 4C 34 12
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (bus.bus_req && bus.bus_addr == 16'h0013) begin
            found = 1'b1;
            break;
         end
      end
      chk("stall_reach", 32'(found), 32'd1);
      ready  = 1'b0;
      base   = inc_cnt;
      stable = 1'b1;
      repeat (5) begin
         @(negedge clk); #1;
         if (!(bus.bus_req && bus.bus_addr == 16'h0013)) stable = 1'b0;
      end
      chk("stall_stable", 32'(stable),         32'd1);
      chk("stall_no_inc", 32'(inc_cnt - base), 32'd0);
      ready = 1'b1;
      @(negedge clk); #1;
      chk("stall_one_inc", 32'(inc_cnt - base), 32'd1);
      chk("stall_next",    32'(bus.bus_addr),   32'h0014);
      chk("stall_byte",    32'(operand_q),      32'h0034);
      ready = 1'b0;

      // Reset while stalled on the second operand byte
      @(negedge clk);
      rst   = 1'b1;
      ready = 1'b1;
      #1;
      chk("rstmid_pc_inc",  32'(pc_inc),  32'd0);
      chk("rstmid_pc_load", 32'(pc_load), 32'd0);
      base = inc_cnt;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstmid_iv",      32'(instr_valid),    32'd0);
      chk("rstmid_operand", 32'(operand_q),      32'h0000);
      chk("rstmid_opcode",  32'(opcode_q),       32'h00);
      chk("rstmid_addr",    32'(bus.bus_addr),   32'hFFFC);
      chk("rstmid_req",     32'(bus.bus_req),    32'd1);
      chk("rstmid_no_inc",  32'(inc_cnt - base), 32'd0);
      ready = 1'b0;

      chk("inc_load_overlap", 32'(both_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
